fp32_add_sub: RTL and testbench
===============================

Name: fp32_add_sub

Overview:
- Pipelined IEEE-754 single-precision adder/subtractor for the FPU execution unit.
- Takes two FP32 operands and an add/sub select, qualified by a one-cycle start pulse.
- Returns the FP32 result with a one-cycle done pulse after a fixed 4-cycle latency.
- Flags an exception for special operands and for overflow.

Parameters:
- LATENCY, 4, pipeline depth from start sample to done. Fixed; the structure below assumes 4.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  operand-valid strobe; operands and AddBar_Sub are sampled on each rising edge where start=1.
- a_operand  input  32  FP32 operand A.
- b_operand  input  32  FP32 operand B.
- AddBar_Sub  input  1  0 = A+B, 1 = A−B.
- result  output  32  FP32 result; valid while done=1.
- Exception  output  1  exception flag; valid while done=1.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - result=0, Exception=0, done=0.
  - All pipeline valid bits cleared; in-flight operations are discarded and produce no done.
- Throughput and handshake:
  - Fully pipelined, no backpressure; one new operation accepted per cycle.
  - Back-to-back starts are legal; results return in issue order.
  - start sampled at edge N gives done=1, result and Exception registered at edge N+4; they hold until edge N+5.
  - When done=0, result and Exception hold their last values.
- Stage 1 (unpack/compare):
  - Effective B sign = b[31] XOR AddBar_Sub.
  - Detect special operands (exponent 0xFF).
  - Swap so the larger magnitude (exponent, then mantissa) is operand X.
  - Compute exponent difference.
- Stage 2 (align/add):
  - Restore hidden 1 (0 for exponent 0).
  - Right-shift Y's 24-bit mantissa by the exponent difference, keeping guard, round and sticky bits.
  - A difference of 26 or more collapses Y to sticky.
  - Add the mantissas if signs are equal, else subtract (X−Y, never negative).
  - Result sign = sign of X.
- Stage 3 (normalize):
  - On carry-out: shift right 1 and exponent+1.
  - Otherwise: leading-zero count, left shift, exponent−LZC.
- Stage 4 (round/pack):
  - Round to nearest, ties to even; a rounding carry renormalizes.
  - Pack sign, 8-bit exponent, 23-bit fraction.
- Zero results:
  - An exact zero sum (e.g. x−x) gives +0 (0x00000000).
  - Both operands zero: sign = AND of the effective signs.
- Exception=1, result=0x7FC00000 (canonical qNaN): either operand has exponent 0xFF (Inf or NaN).
- Overflow: final exponent ≥ 255 gives Exception=1, result = signed Inf (0x7F800000 or 0xFF800000).
- Underflow: final exponent ≤ 0 gives signed zero with Exception=0 (see optional feature).
- Subnormal inputs are treated as zero (see optional feature).

Optional Feature:
- Macro FP_ADD_SUB_DENORM_EN.
- Defined:
  - Subnormal inputs use hidden bit 0 and effective exponent 1.
  - Results below the normal range are denormalized (right-shifted with sticky) and rounded, giving gradual underflow.
- Undefined: flush-to-zero on inputs and outputs, as described in Behaviour.

Test Plan:
- 0x3FC00000 + 0x40200000 (1.5+2.5), AddBar_Sub=0 → result 0x40800000, Exception 0, done exactly 4 cycles after start.
- 0x41200000 + 0x40000000 (10+2) → 0x41400000. 0x3F800000 + 0x3F800000 (1+1) → 0x40000000 (carry renormalization).
- 0x40B00000 − 0x3FC00000 (5.5−1.5), AddBar_Sub=1 → 0x40800000. 0x3F800000 − 0x3F800000 → 0x00000000, Exception 0.
- 0x7F800000 + 0x40000000 (Inf+2) → Exception 1, result 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF → Exception 1, result 0x7F800000.
- Starts on 4 consecutive cycles with the above operand pairs → 4 consecutive done pulses, results in order.
- Deassert rst_n with 2 operations in flight → outputs clear immediately, no done afterward. 0x3F800000 + 0x33800000 (1+2^-24, tie) → 0x3F800000 (round to even).

Source files
------------

// File: rtl/fp32_add_sub.sv
// fp32_add_sub: 4-stage pipelined IEEE-754 single-precision add/subtract.
// Define FP_ADD_SUB_DENORM_EN for subnormal inputs and gradual underflow.
module fp32_add_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic [31:0] result,
  output logic        Exception,
  output logic        done
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        a_s, b_s, a_z, b_z, swap;
  logic [7:0]  a_e, b_e, a_ee, b_ee;
  logic [23:0] a_m, b_m;

  assign a_s = a_operand[31];
  assign b_s = b_operand[31] ^ AddBar_Sub;
  assign a_e = a_operand[30:23];
  assign b_e = b_operand[30:23];

  always_comb begin
`ifdef FP_ADD_SUB_DENORM_EN
    a_z  = (a_e == 8'd0) && (a_operand[22:0] == 23'd0);
    b_z  = (b_e == 8'd0) && (b_operand[22:0] == 23'd0);
    a_ee = (a_e == 8'd0) ? 8'd1 : a_e;
    b_ee = (b_e == 8'd0) ? 8'd1 : b_e;
    a_m  = {a_e != 8'd0, a_operand[22:0]};
    b_m  = {b_e != 8'd0, b_operand[22:0]};
`else
    a_z  = a_e == 8'd0;
    b_z  = b_e == 8'd0;
    a_ee = a_e;
    b_ee = b_e;
    a_m  = a_z ? 24'd0 : {1'b1, a_operand[22:0]};
    b_m  = b_z ? 24'd0 : {1'b1, b_operand[22:0]};
`endif
    swap = {b_ee, b_m} > {a_ee, a_m};
  end

  logic        v1, sp1, bz1, zs1, op1, xs1;
  logic [7:0]  xe1, d1;
  logic [23:0] xm1, ym1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      sp1 <= 1'b0;
      bz1 <= 1'b0;
      zs1 <= 1'b0;
      op1 <= 1'b0;
      xs1 <= 1'b0;
      xe1 <= 8'd0;
      d1  <= 8'd0;
      xm1 <= 24'd0;
      ym1 <= 24'd0;
    end else begin
      v1  <= start;
      sp1 <= (a_e == 8'hFF) || (b_e == 8'hFF);
      bz1 <= a_z && b_z;
      zs1 <= a_s && b_s;
      op1 <= a_s ^ b_s;
      xs1 <= swap ? b_s : a_s;
      xe1 <= swap ? b_ee : a_ee;
      d1  <= swap ? (b_ee - a_ee) : (a_ee - b_ee);
      xm1 <= swap ? b_m : a_m;
      ym1 <= swap ? a_m : b_m;
    end
  end

  // Y aligned as 24-bit mantissa + guard + round + sticky
  logic [49:0] ext;
  logic [26:0] al;
  logic [27:0] sum;

  always_comb begin
    ext = {ym1, 26'd0} >> d1;
    if (d1 >= 8'd26) al = {26'd0, |ym1};
    else             al = {ext[49:24], |ext[23:0]};
    if (op1) sum = {1'b0, xm1, 3'd0} - {1'b0, al};
    else     sum = {1'b0, xm1, 3'd0} + {1'b0, al};
  end

  logic        v2, sp2, bz2, zs2, s2s;
  logic [7:0]  e2;
  logic [27:0] sum2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      sp2  <= 1'b0;
      bz2  <= 1'b0;
      zs2  <= 1'b0;
      s2s  <= 1'b0;
      e2   <= 8'd0;
      sum2 <= 28'd0;
    end else begin
      v2   <= v1;
      sp2  <= sp1;
      bz2  <= bz1;
      zs2  <= zs1;
      s2s  <= xs1;
      e2   <= xe1;
      sum2 <= sum;
    end
  end

  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne;

  always_comb begin
    lz = lzc27(sum2[26:0]);
    if (sum2[27]) begin
      nm = {sum2[27:2], |sum2[1:0]};
      ne = $signed({2'd0, e2}) + 10'sd1;
    end else begin
      nm = sum2[26:0] << lz;
      ne = $signed({2'd0, e2}) - $signed({5'd0, lz});
    end
  end

  logic              v3, sp3, bz3, zs3, z3, s3s;
  logic signed [9:0] e3;
  logic [26:0]       m3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      sp3 <= 1'b0;
      bz3 <= 1'b0;
      zs3 <= 1'b0;
      z3  <= 1'b0;
      s3s <= 1'b0;
      e3  <= 10'sd0;
      m3  <= 27'd0;
    end else begin
      v3  <= v2;
      sp3 <= sp2;
      bz3 <= bz2;
      zs3 <= zs2;
      z3  <= sum2 == 28'd0;
      s3s <= s2s;
      e3  <= ne;
      m3  <= nm;
    end
  end

  logic [26:0]       rm;
  logic              inc;
  logic [24:0]       mr;
  logic signed [9:0] ef;
  logic [22:0]       fr;
`ifdef FP_ADD_SUB_DENORM_EN
  logic [9:0]        sh;
  logic [53:0]       tmp;
`endif

  always_comb begin
    rm = m3;
`ifdef FP_ADD_SUB_DENORM_EN
    sh  = 10'd1 - e3;
    tmp = {m3, 27'd0} >> sh;
    if (e3 < 10'sd1) begin
      if (sh >= 10'd27) rm = {26'd0, |m3};
      else              rm = {tmp[53:28], |tmp[27:0]};
    end
`endif
    inc = rm[2] & (rm[1] | rm[0] | rm[3]);
    mr  = {1'b0, rm[26:3]} + {24'd0, inc};
    ef  = e3 + $signed({9'd0, mr[24]});
    fr  = mr[24] ? mr[23:1] : mr[22:0];
`ifdef FP_ADD_SUB_DENORM_EN
    // a rounding carry into the hidden bit promotes to the smallest normal
    if (e3 < 10'sd1) begin
      ef = mr[23] ? 10'sd1 : 10'sd0;
      fr = mr[22:0];
    end
`endif
  end

  logic              v4, sp4, bz4, zs4, z4, s4s;
  logic signed [9:0] ef4;
  logic [22:0]       fr4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4  <= 1'b0;
      sp4 <= 1'b0;
      bz4 <= 1'b0;
      zs4 <= 1'b0;
      z4  <= 1'b0;
      s4s <= 1'b0;
      ef4 <= 10'sd0;
      fr4 <= 23'd0;
    end else begin
      v4  <= v3;
      sp4 <= sp3;
      bz4 <= bz3;
      zs4 <= zs3;
      z4  <= z3;
      s4s <= s3s;
      ef4 <= ef;
      fr4 <= fr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= 32'd0;
      Exception <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= v4;
      if (v4) begin
        Exception <= 1'b0;
        if (sp4) begin
          result    <= 32'h7FC0_0000;
          Exception <= 1'b1;
        end else if (bz4) begin
          result <= {zs4, 31'd0};
        end else if (z4) begin
          result <= 32'd0;
        end else if (ef4 >= 10'sd255) begin
          result    <= {s4s, 8'hFF, 23'd0};
          Exception <= 1'b1;
        end else if (ef4 <= 10'sd0) begin
`ifdef FP_ADD_SUB_DENORM_EN
          result <= {s4s, 8'd0, fr4};
`else
          result <= {s4s, 31'd0};
`endif
        end else begin
          result <= {s4s, ef4[7:0], fr4};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_add_sub.sv
// tb_fp32_add_sub: directed-vector bench for fp32_add_sub.
// Checks latency, arithmetic, specials, rounding, pipelining and reset.
module tb_fp32_add_sub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [31:0] result;
  logic        exc;
  logic        done;
  int          checks;
  int          fails;

  fp32_add_sub dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a_operand(a),
    .b_operand(b),
    .AddBar_Sub(sub),
    .result(result),
    .Exception(exc),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2,
                        input logic ts, input logic [31:0] er,
                        input logic ee, input string nm);
    int lat;
    lat = 0;
    a = ta;
    b = tb2;
    sub = ts;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL %s latency: got %0d, expected 4", nm, lat);
    end
    checks++;
    if (result !== er) begin
      fails++;
      $display("FAIL %s result: got %h, expected %h", nm, result, er);
    end
    checks++;
    if (exc !== ee) begin
      fails++;
      $display("FAIL %s exception: got %b, expected %b", nm, exc, ee);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || result !== er) begin
      fails++;
      $display("FAIL %s hold: done=%b result=%h, expected done=0 result=%h",
               nm, done, result, er);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0 || exc !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: result=%h exc=%b done=%b, expected 0/0/0",
               result, exc, done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    run_op(32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 1'b0, "add_1.5_2.5");
    run_op(32'h41200000, 32'h40000000, 1'b0, 32'h41400000, 1'b0, "add_10_2");
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, "add_1_1");
  endtask

  task automatic test_sub;
    run_op(32'h40B00000, 32'h3FC00000, 1'b1, 32'h40800000, 1'b0, "sub_5.5_1.5");
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, "sub_1_1");
    run_op(32'h40000000, 32'h40B00000, 1'b1, 32'hC0600000, 1'b0, "sub_2_5.5");
  endtask

  task automatic test_special;
    run_op(32'h7F800000, 32'h40000000, 1'b0, 32'h7FC00000, 1'b1, "inf_plus_2");
    run_op(32'h3F800000, 32'h7FC00000, 1'b1, 32'h7FC00000, 1'b1, "one_minus_nan");
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, "ovf_pos");
    run_op(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b1, "ovf_neg");
  endtask

  task automatic test_zero;
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, "negz_plus_negz");
    run_op(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, "posz_plus_negz");
    run_op(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, "negz_minus_posz");
  endtask

  task automatic test_round;
    run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, "tie_even_down");
    run_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, "tie_even_up");
    run_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, "above_half");
  endtask

  task automatic test_underflow;
`ifdef FP_ADD_SUB_DENORM_EN
    run_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 1'b0, "tiny_diff");
`else
    run_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, "tiny_diff");
`endif
    run_op(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, "subnormal_in");
  endtask

  task automatic test_back_to_back;
    logic [31:0] ta[4] = '{32'h3FC00000, 32'h41200000, 32'h40B00000, 32'h7F800000};
    logic [31:0] tb2[4] = '{32'h40200000, 32'h40000000, 32'h3FC00000, 32'h40000000};
    logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] er[4] = '{32'h40800000, 32'h41400000, 32'h40800000, 32'h7FC00000};
    logic        ee[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int idx;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        a = ta[c];
        b = tb2[c];
        sub = ts[c];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        if (idx < 4) begin
          checks++;
          if (result !== er[idx] || exc !== ee[idx] || c !== idx + 4) begin
            fails++;
            $display("FAIL b2b[%0d]: result=%h exc=%b edge=%0d, expected %h %b %0d",
                     idx, result, exc, c, er[idx], ee[idx], idx + 4);
          end
        end
        idx++;
      end
    end
    start = 1'b0;
    checks++;
    if (idx !== 4) begin
      fails++;
      $display("FAIL b2b count: got %0d done pulses, expected 4", idx);
    end
  endtask

  task automatic test_reset_inflight;
    int seen;
    seen = 0;
    a = 32'h3FC00000;
    b = 32'h40200000;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 a = 32'h41200000;
    b = 32'h40000000;
    @(posedge clk);
    #1 start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 32'd0 || exc !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_inflight clear: result=%h exc=%b done=%b, expected 0/0/0",
               result, exc, done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_inflight done: got %0d pulses, expected 0", seen);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    sub = 1'b0;
    checks = 0;
    fails = 0;
    test_reset;
    test_add;
    test_sub;
    test_special;
    test_zero;
    test_round;
    test_underflow;
    test_back_to_back;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, "pre_reset");
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
